// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small function and checks y_i against EXP.
// Define TT_CHECK_STOP_ON_FAIL_EN to end a run at the first mismatching sample.
module truth_table_checker #(
    parameter int                 N_IN   = 3,
    parameter int                 SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXP    = 8'h31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            y_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam int CW = ($clog2(SETTLE + 1) > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};
`ifdef TT_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          fail_seen;
    logic          sample;
    logic          mismatch;
    logic          last_step;

    assign sample    = (state == RUN) && (cnt == SETTLE_C);
    assign mismatch  = sample && (y_i != EXP[vec_o]);
    assign last_step = (vec_o == LAST) || (STOP_ON_FAIL && mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            fail_seen      <= 1'b0;
            vec_o          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        vec_o     <= '0;
                        err_cnt   <= '0;
                        pass      <= 1'b0;
                        fail_seen <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (sample) begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + 1'b1;
                            if (!fail_seen) begin
                                first_fail_idx <= vec_o;
                                fail_seen      <= 1'b1;
                            end
                        end
                        // pass must include the sample taken on this final edge
                        if (last_step) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !fail_seen && !mismatch;
                        end else begin
                            vec_o <= vec_o + 1'b1;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: scoreboard bench for truth_table_checker.
// Runs a SETTLE=1 and a SETTLE=3 instance against a golden ~b&~c | a&~b model.
module tb_truth_table_checker;

`ifdef TT_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        bit pass;
        int err;
        int ffi;
        int vlast;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    int mode = 0;
    bit sel = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    logic start0 = 1'b0, start3 = 1'b0, y0, y3;
    logic [2:0] vec0, vec3, ffi0, ffi3;
    logic busy0, busy3, done0, done3, pass0, pass3;
    logic [3:0] err0, err3;

    truth_table_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_i(y0),
        .vec_o(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail_idx(ffi0)
    );

    truth_table_checker #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .y_i(y3),
        .vec_o(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .first_fail_idx(ffi3)
    );

    logic [2:0] o_vec, o_ffi;
    logic o_busy, o_done, o_pass;
    logic [3:0] o_err;
    assign o_vec  = sel ? vec3 : vec0;
    assign o_ffi  = sel ? ffi3 : ffi0;
    assign o_busy = sel ? busy3 : busy0;
    assign o_done = sel ? done3 : done0;
    assign o_pass = sel ? pass3 : pass0;
    assign o_err  = sel ? err3 : err0;

    function automatic bit f(input logic [2:0] v);
        bit a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (~b & ~c) | (a & ~b);
    endfunction

    // mode 0 correct, 1 tied low, 2 wrong except in the cycle before a sample edge
    always_comb begin
        y0 = (mode == 1) ? 1'b0 : f(vec0) ^ ((mode == 2) && (((cyc - t0 + 1) % 2) != 0));
        y3 = (mode == 1) ? 1'b0 : f(vec3) ^ ((mode == 2) && (((cyc - t0 + 1) % 4) != 0));
    end

    function automatic exp_t predict(input int m, input int p);
        exp_t e;
        bit yv;
        e.err = 0;
        e.ffi = 0;
        e.vlast = 7;
        e.lat = 8 * p;
        for (int v = 0; v < 8; v++) begin
            yv = (m == 1) ? 1'b0 : f(3'(v));
            if (yv != f(3'(v))) begin
                if (e.err == 0) e.ffi = v;
                e.err++;
                if (STOP) begin
                    e.vlast = v;
                    e.lat = (v + 1) * p;
                    break;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic accept(input int m, input bit hold);
        mode = m;
        @(negedge clk);
        if (sel) start3 = 1'b1;
        else start0 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        sbq.push_back(predict(m, sel ? 4 : 2));
        if (!hold) begin
            start0 = 1'b0;
            start3 = 1'b0;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        n_chk++; if (vec0 !== 3'd0) begin n_fail++; $display("FAIL rst vec got %0d exp 0", vec0); end
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst busy got %b exp 0", busy0); end
        n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst done got %b exp 0", done0); end
        n_chk++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL rst pass got %b exp 0", pass0); end
        n_chk++; if (err0 !== 4'd0) begin n_fail++; $display("FAIL rst err got %0d exp 0", err0); end
        n_chk++; if (ffi0 !== 3'd0) begin n_fail++; $display("FAIL rst ffi got %0d exp 0", ffi0); end
        n_chk++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rst busy3 got %b exp 0", busy3); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst idle busy got %b exp 0", busy0); end
    endtask

    task automatic test_basic();
        exp_t e;
        int lat;
        sel = 1'b0;
        accept(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_chk++; if (vec0 !== 3'((cyc - t0) / 2)) begin n_fail++; $display("FAIL basic vec rel=%0d got %0d exp %0d", cyc - t0, vec0, (cyc - t0) / 2); end
            n_chk++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin n_fail++; $display("FAIL basic busy/done rel=%0d got %b/%b exp 1/0", cyc - t0, busy0, done0); end
        end
        wait_done(lat);
        e = sbq.pop_front();
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL basic lat got %0d exp %0d", lat, e.lat); end
        n_chk++; if (pass0 !== e.pass) begin n_fail++; $display("FAIL basic pass got %b exp %b", pass0, e.pass); end
        n_chk++; if (err0 !== 4'(e.err)) begin n_fail++; $display("FAIL basic err got %0d exp %0d", err0, e.err); end
        n_chk++; if (vec0 !== 3'(e.vlast)) begin n_fail++; $display("FAIL basic vec_last got %0d exp %0d", vec0, e.vlast); end
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic busy_done got %b exp 0", busy0); end
        @(negedge clk);
        n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL basic done_width got %b exp 0", done0); end
        n_chk++; if (pass0 !== e.pass) begin n_fail++; $display("FAIL basic pass_hold got %b exp %b", pass0, e.pass); end
    endtask

    task automatic test_tied0();
        exp_t e;
        int lat;
        sel = 1'b0;
        accept(1, 1'b0);
        wait_done(lat);
        e = sbq.pop_front();
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL tied0 lat got %0d exp %0d", lat, e.lat); end
        n_chk++; if (pass0 !== e.pass) begin n_fail++; $display("FAIL tied0 pass got %b exp %b", pass0, e.pass); end
        n_chk++; if (err0 !== 4'(e.err)) begin n_fail++; $display("FAIL tied0 err got %0d exp %0d", err0, e.err); end
        n_chk++; if (ffi0 !== 3'(e.ffi)) begin n_fail++; $display("FAIL tied0 ffi got %0d exp %0d", ffi0, e.ffi); end
        n_chk++; if (vec0 !== 3'(e.vlast)) begin n_fail++; $display("FAIL tied0 vec_last got %0d exp %0d", vec0, e.vlast); end
        repeat (3) @(negedge clk);
        n_chk++; if (err0 !== 4'(e.err)) begin n_fail++; $display("FAIL tied0 err_hold got %0d exp %0d", err0, e.err); end
    endtask

    task automatic test_glitch();
        exp_t e;
        int lat;
        sel = 1'b0;
        accept(2, 1'b0);
        wait_done(lat);
        e = sbq.pop_front();
        mode = 0;
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL glitch lat got %0d exp %0d", lat, e.lat); end
        n_chk++; if (pass0 !== e.pass) begin n_fail++; $display("FAIL glitch pass got %b exp %b", pass0, e.pass); end
        n_chk++; if (err0 !== 4'(e.err)) begin n_fail++; $display("FAIL glitch err got %0d exp %0d", err0, e.err); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        sel = 1'b1;
        accept(1, 1'b1);
        wait_done(lat);
        e = sbq.pop_front();
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b lat1 got %0d exp %0d", lat, e.lat); end
        n_chk++; if (err3 !== 4'(e.err)) begin n_fail++; $display("FAIL b2b err1 got %0d exp %0d", err3, e.err); end
        n_chk++; if (pass3 !== e.pass) begin n_fail++; $display("FAIL b2b pass1 got %b exp %b", pass3, e.pass); end
        mode = 0;
        @(posedge clk);
        #1;
        t0 = cyc;
        sbq.push_back(predict(0, 4));
        @(negedge clk);
        start3 = 1'b0;
        n_chk++; if (busy3 !== 1'b1 || done3 !== 1'b0) begin n_fail++; $display("FAIL b2b restart busy/done got %b/%b exp 1/0", busy3, done3); end
        n_chk++; if (err3 !== 4'd0) begin n_fail++; $display("FAIL b2b err_clear got %0d exp 0", err3); end
        n_chk++; if (vec3 !== 3'd0) begin n_fail++; $display("FAIL b2b vec_clear got %0d exp 0", vec3); end
        wait_done(lat);
        e = sbq.pop_front();
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b lat2 got %0d exp %0d", lat, e.lat); end
        n_chk++; if (pass3 !== e.pass) begin n_fail++; $display("FAIL b2b pass2 got %b exp %b", pass3, e.pass); end
        n_chk++; if (err3 !== 4'(e.err)) begin n_fail++; $display("FAIL b2b err2 got %0d exp %0d", err3, e.err); end
        @(negedge clk);
        n_chk++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL b2b idle busy got %b exp 0", busy3); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        bit any_done;
        sel = 1'b0;
        accept(0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sbq.pop_front());
        n_chk++; if (vec0 !== 3'd0) begin n_fail++; $display("FAIL rmid vec got %0d exp 0", vec0); end
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid busy got %b exp 0", busy0); end
        n_chk++; if (err0 !== 4'd0 || pass0 !== 1'b0) begin n_fail++; $display("FAIL rmid err/pass got %0d/%b exp 0/0", err0, pass0); end
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any_done |= done0;
        end
        n_chk++; if (any_done !== 1'b0) begin n_fail++; $display("FAIL rmid done_pulse got %b exp 0", any_done); end
        rst_n = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start0 = 1'b0;
        sbq.push_back(predict(0, 2));
        wait_done(lat);
        e = sbq.pop_front();
        n_chk++; if (lat !== e.lat) begin n_fail++; $display("FAIL rmid lat got %0d exp %0d", lat, e.lat); end
        n_chk++; if (pass0 !== e.pass) begin n_fail++; $display("FAIL rmid pass got %b exp %b", pass0, e.pass); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tied0();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
